// File: rtl/broadcast_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : broadcast_ctrl_pkg
//  Description : Shared types and constants for the broadcast controller.
//                Holds the controller state encoding, the beat size and the
//                common width constants used by broadcast_unit users.
//  Revision    : 1.0 - initial release
// ============================================================================
package broadcast_ctrl_pkg;

    localparam int BEAT_BYTES     = 8;
    localparam int INT8_SIZE      = 8;
    localparam int MAX_ADDR_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_FILL   = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } bcast_ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/broadcast_ctrl_credit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : credit_counter
//  Description : Saturating up/down credit counter with reset/init value,
//                zero flag and full flag. Reusable by any stream producer.
//  Ports       : clk, rst    - clock, synchronous active-high reset
//                inc_i       - one credit returned
//                dec_i       - one credit consumed
//                count_o     - current credit count
//                zero_o      - no credits available
//                full_o      - count equals MAX
//  Revision    : 1.0 - initial release
// ============================================================================
module credit_counter #(
    parameter int WIDTH = 3,
    parameter int INIT  = 4,
    parameter int MAX   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] count_o,
    output logic             zero_o,
    output logic             full_o
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);
    assign full_o  = (count_q == WIDTH'(MAX));

    // A consume and a return in the same cycle cancel out; returns beyond
    // MAX and consumes below zero are dropped.
    always_comb begin
        count_d = count_q;
        if (inc_i && dec_i) begin
            count_d = count_q;
        end else if (inc_i && !full_o) begin
            count_d = count_q + WIDTH'(1);
        end else if (dec_i && !zero_o) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= WIDTH'(INIT);
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/broadcast_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : broadcast_ctrl
//  Description : Sequences one broadcast_unit through an operand-broadcast
//                job: clear cache, fill it from SRAM in 8-byte beats, then
//                issue the requested number of output beats under downstream
//                credit control and wait for all of them to come back.
//  Ports       : start_i/base_addr_i/num_elem_i/num_beats_i - job request
//                sram_*      - SRAM read port (in-order responses)
//                bu_*_o      - broadcast_unit controls / cache write port
//                bu_valid_i  - broadcast_unit output valid
//                credit_ret_i- downstream freed one slot
//                busy_o, done_o, err_o - job status to the scheduler
//  Options     : BCAST_CTRL_PERF_EN adds perf_fill_cyc_o / perf_stall_cyc_o
//  Revision    : 1.0 - initial release
// ============================================================================
module broadcast_ctrl #(
    parameter int MAX_VECTOR_SIZE = 8,
    parameter int CACHE_DEPTH     = 512,
    parameter int MAX_ADDR_WIDTH  = 32,
    parameter int BEAT_CNT_WIDTH  = 16,
    parameter int CREDITS         = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic [MAX_ADDR_WIDTH-1:0] base_addr_i,
    input  logic [31:0]               num_elem_i,
    input  logic [BEAT_CNT_WIDTH-1:0] num_beats_i,
    output logic                      sram_req_o,
    output logic [MAX_ADDR_WIDTH-1:0] sram_addr_o,
    input  logic                      sram_gnt_i,
    input  logic                      sram_rvalid_i,
    input  logic [63:0]               sram_rdata_i,
    output logic                      bu_init_o,
    output logic                      bu_valid_o,
    output logic [MAX_ADDR_WIDTH-1:0] bu_addr_o,
    output logic [63:0]               bu_data_o,
    output logic                      bu_en_o,
    output logic [31:0]               bu_nelem_o,
    input  logic                      bu_valid_i,
    input  logic                      credit_ret_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o
`ifdef BCAST_CTRL_PERF_EN
    ,
    output logic [31:0]               perf_fill_cyc_o,
    output logic [31:0]               perf_stall_cyc_o
`endif
);

    import broadcast_ctrl_pkg::*;

    localparam int BEAT_SHIFT = $clog2(MAX_VECTOR_SIZE);
    localparam int FILL_CNT_W = $clog2(CACHE_DEPTH / MAX_VECTOR_SIZE) + 1;
    localparam int CRED_W     = $clog2(CREDITS + 1);

    bcast_ctrl_state_t state_d, state_q;

    logic [MAX_ADDR_WIDTH-1:0] base_d, base_q;
    logic [31:0]               nelem_d, nelem_q;
    logic [31:0]               bu_nelem_d, bu_nelem_q;
    logic [BEAT_CNT_WIDTH-1:0] beats_d, beats_q;
    logic                      err_d, err_q;
    logic [FILL_CNT_W-1:0]     req_cnt_d, req_cnt_q;
    logic [FILL_CNT_W-1:0]     rsp_cnt_d, rsp_cnt_q;
    logic [BEAT_CNT_WIDTH-1:0] issued_d, issued_q;
    logic [BEAT_CNT_WIDTH-1:0] received_d, received_q;

    logic [31:0]               w_fill_beats;
    logic                      w_req_more;
    logic                      w_rsp_more;
    logic                      w_issue_more;
    logic                      w_cred_zero;
    logic                      w_cred_full;
    logic [CRED_W-1:0]         w_cred_cnt;
    logic                      w_unused_cred;

    // ------------------------------------------------------------------
    // Downstream credits
    // ------------------------------------------------------------------
    credit_counter #(
        .WIDTH (CRED_W),
        .INIT  (CREDITS),
        .MAX   (CREDITS)
    ) u_credit_counter (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (credit_ret_i),
        .dec_i   (bu_en_o),
        .count_o (w_cred_cnt),
        .zero_o  (w_cred_zero),
        .full_o  (w_cred_full)
    );

    assign w_unused_cred = ^{w_cred_cnt, w_cred_full};

    // ------------------------------------------------------------------
    // Datapath decode
    // ------------------------------------------------------------------
    assign w_fill_beats = (nelem_q + 32'(MAX_VECTOR_SIZE - 1)) >> BEAT_SHIFT;
    assign w_req_more   = (32'(req_cnt_q) < w_fill_beats);
    assign w_rsp_more   = (32'(rsp_cnt_q) < w_fill_beats);
    assign w_issue_more = (issued_q < beats_q);

    assign sram_req_o  = (state_q == ST_FILL) && w_req_more;
    assign sram_addr_o = sram_req_o
                       ? base_q + (MAX_ADDR_WIDTH'(req_cnt_q) << BEAT_SHIFT)
                       : '0;

    // SRAM read data is forwarded straight into the cache; responses that
    // arrive outside FILL (e.g. stragglers after a reset) are dropped here.
    assign bu_valid_o = (state_q == ST_FILL) && sram_rvalid_i && w_rsp_more;
    assign bu_data_o  = bu_valid_o ? sram_rdata_i : '0;
    assign bu_addr_o  = bu_valid_o ? (MAX_ADDR_WIDTH'(rsp_cnt_q) << BEAT_SHIFT) : '0;

    assign bu_en_o    = (state_q == ST_STREAM) && !w_cred_zero && w_issue_more;

    assign bu_init_o  = (state_q == ST_INIT);
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = (state_q == ST_DONE);
    assign err_o      = (state_q == ST_DONE) && err_q;
    assign bu_nelem_o = bu_nelem_q;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        nelem_d    = nelem_q;
        bu_nelem_d = bu_nelem_q;
        beats_d    = beats_q;
        err_d      = err_q;
        req_cnt_d  = req_cnt_q;
        rsp_cnt_d  = rsp_cnt_q;
        issued_d   = issued_q;
        received_d = received_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    base_d  = base_addr_i;
                    nelem_d = num_elem_i;
                    beats_d = num_beats_i;
                    if ((num_elem_i == 32'd0) || (num_elem_i > 32'(CACHE_DEPTH)) ||
                        (num_beats_i == '0)) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_INIT;
                    end
                end
            end

            ST_INIT: begin
                // The unit only sees the new length once its cache is being
                // cleared, so a rejected job never disturbs its wrap point.
                bu_nelem_d = nelem_q;
                req_cnt_d  = '0;
                rsp_cnt_d  = '0;
                issued_d   = '0;
                received_d = '0;
                state_d    = ST_FILL;
            end

            ST_FILL: begin
                if (sram_req_o && sram_gnt_i) begin
                    req_cnt_d = req_cnt_q + FILL_CNT_W'(1);
                end
                if (bu_valid_o) begin
                    rsp_cnt_d = rsp_cnt_q + FILL_CNT_W'(1);
                    if ((32'(rsp_cnt_q) + 32'd1) == w_fill_beats) begin
                        state_d = ST_STREAM;
                    end
                end
            end

            ST_STREAM: begin
                // Unit outputs can already come back while still issuing.
                if (bu_valid_i) begin
                    received_d = received_q + BEAT_CNT_WIDTH'(1);
                end
                if (bu_en_o) begin
                    issued_d = issued_q + BEAT_CNT_WIDTH'(1);
                    if (issued_d == beats_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                if (bu_valid_i) begin
                    received_d = received_q + BEAT_CNT_WIDTH'(1);
                end
                if (received_d == beats_q) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            nelem_q    <= '0;
            bu_nelem_q <= '0;
            beats_q    <= '0;
            err_q      <= 1'b0;
            req_cnt_q  <= '0;
            rsp_cnt_q  <= '0;
            issued_q   <= '0;
            received_q <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            nelem_q    <= nelem_d;
            bu_nelem_q <= bu_nelem_d;
            beats_q    <= beats_d;
            err_q      <= err_d;
            req_cnt_q  <= req_cnt_d;
            rsp_cnt_q  <= rsp_cnt_d;
            issued_q   <= issued_d;
            received_q <= received_d;
        end
    end

`ifdef BCAST_CTRL_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters: cleared at INIT, frozen once the job is over.
    // ------------------------------------------------------------------
    logic [31:0] perf_fill_d, perf_fill_q;
    logic [31:0] perf_stall_d, perf_stall_q;

    always_comb begin
        perf_fill_d  = perf_fill_q;
        perf_stall_d = perf_stall_q;
        if (state_q == ST_INIT) begin
            perf_fill_d  = '0;
            perf_stall_d = '0;
        end else begin
            if (state_q == ST_FILL) begin
                perf_fill_d = perf_fill_q + 32'd1;
            end
            if ((state_q == ST_STREAM) && w_issue_more && w_cred_zero) begin
                perf_stall_d = perf_stall_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fill_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_fill_q  <= perf_fill_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_fill_cyc_o  = perf_fill_q;
    assign perf_stall_cyc_o = perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_broadcast_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_broadcast_ctrl
//  Description : Directed self-checking bench for broadcast_ctrl with an
//                SRAM responder, a downstream/credit model and a scoreboard
//                of expected SRAM reads and cache writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_broadcast_ctrl;

    localparam int CREDITS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] base_addr_i = '0;
    logic [31:0] num_elem_i = '0;
    logic [15:0] num_beats_i = '0;
    logic        sram_req_o;
    logic [31:0] sram_addr_o;
    logic        sram_gnt_i = 1'b1;
    logic        sram_rvalid_i;
    logic [63:0] sram_rdata_i;
    logic        bu_init_o;
    logic        bu_valid_o;
    logic [31:0] bu_addr_o;
    logic [63:0] bu_data_o;
    logic        bu_en_o;
    logic [31:0] bu_nelem_o;
    logic        bu_valid_i = 1'b0;
    logic        credit_ret_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    always #5 clk = ~clk;

    broadcast_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .base_addr_i   (base_addr_i),
        .num_elem_i    (num_elem_i),
        .num_beats_i   (num_beats_i),
        .sram_req_o    (sram_req_o),
        .sram_addr_o   (sram_addr_o),
        .sram_gnt_i    (sram_gnt_i),
        .sram_rvalid_i (sram_rvalid_i),
        .sram_rdata_i  (sram_rdata_i),
        .bu_init_o     (bu_init_o),
        .bu_valid_o    (bu_valid_o),
        .bu_addr_o     (bu_addr_o),
        .bu_data_o     (bu_data_o),
        .bu_en_o       (bu_en_o),
        .bu_nelem_o    (bu_nelem_o),
        .bu_valid_i    (bu_valid_i),
        .credit_ret_i  (credit_ret_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o)
    );

    int checks = 0;
    int errors = 0;

    function automatic logic [63:0] data_of(input logic [31:0] a);
        return {a ^ 32'h5A5A_0F0F, ~a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // SRAM: read data returns two cycles after the grant, in order.
    logic [1:0]  rv_pipe = 2'b00;
    logic [31:0] ra_pipe0 = '0;
    logic [31:0] ra_pipe1 = '0;
    always @(posedge clk) begin
        rv_pipe  <= {rv_pipe[0], sram_req_o && sram_gnt_i};
        ra_pipe0 <= sram_addr_o;
        ra_pipe1 <= ra_pipe0;
    end
    assign sram_rvalid_i = rv_pipe[1];
    assign sram_rdata_i  = rv_pipe[1] ? data_of(ra_pipe1) : 64'h0;

    // Downstream: each en yields a unit output next cycle; slots are
    // returned one per cycle while ret_en is set.
    logic ret_en = 1'b1;
    int   pend = 0;
    always @(posedge clk) begin
        int p;
        bu_valid_i <= bu_en_o;
        if (rst) begin
            pend         <= 0;
            credit_ret_i <= 1'b0;
        end else begin
            p = pend + (bu_valid_i ? 1 : 0);
            if (ret_en && p > 0) begin
                credit_ret_i <= 1'b1;
                p = p - 1;
            end else begin
                credit_ret_i <= 1'b0;
            end
            pend <= p;
        end
    end

    // Scoreboard
    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
    } wr_t;

    logic [31:0] exp_req_q[$];
    wr_t         exp_wr_q[$];
    int          en_cnt = 0;
    int          gnt_cnt = 0;
    int          done_cnt = 0;
    int          mcred = CREDITS;
    wr_t         e;

    always @(negedge clk) begin
        if (rst) begin
            exp_req_q.delete();
            exp_wr_q.delete();
            mcred = CREDITS;
        end else begin
            if (sram_req_o && sram_gnt_i) begin
                gnt_cnt++;
                if (exp_req_q.size() == 0) chk("sram_req_unexpected", {32'h0, sram_addr_o}, 64'hDEAD_BEEF_0000_0000);
                else chk("sram_addr", {32'h0, sram_addr_o}, {32'h0, exp_req_q.pop_front()});
            end
            if (bu_valid_o) begin
                if (exp_wr_q.size() == 0) begin
                    chk("bu_wr_unexpected", {32'h0, bu_addr_o}, 64'hDEAD_BEEF_0000_0000);
                end else begin
                    e = exp_wr_q.pop_front();
                    chk("bu_addr", {32'h0, bu_addr_o}, {32'h0, e.addr});
                    chk("bu_data", bu_data_o, e.data);
                end
            end
            if (bu_en_o) begin
                en_cnt++;
                chk("en_with_credit", {63'h0, mcred > 0}, 64'h1);
            end
            if (done_o) done_cnt++;
            if (bu_en_o && credit_ret_i) mcred = mcred;
            else if (credit_ret_i && mcred < CREDITS) mcred++;
            else if (bu_en_o && mcred > 0) mcred--;
        end
    end

    // Per-job expectations
    int          e0, g0, d0;
    int          exp_reads;
    logic [15:0] exp_beats;
    bit          exp_err;
    logic [31:0] last_n = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [31:0] base, input logic [31:0] n, input logic [15:0] beats);
        bit bad;
        int fb;
        bad = (n == 0) || (n > 512) || (beats == 0);
        fb  = int'((n + 32'd7) / 32'd8);
        if (!bad) begin
            for (int i = 0; i < fb; i++) begin
                exp_req_q.push_back(base + 32'(8 * i));
                exp_wr_q.push_back('{addr: 32'(8 * i), data: data_of(base + 32'(8 * i))});
            end
            last_n = n;
        end
        exp_beats = beats;
        exp_err   = bad;
        exp_reads = bad ? 0 : fb;
        e0 = en_cnt;
        g0 = gnt_cnt;
        d0 = done_cnt;
        base_addr_i = base;
        num_elem_i  = n;
        num_beats_i = beats;
        start_i     = 1'b1;
        tick();
        start_i = 1'b0;
        @(negedge clk);
        chk("init_pulse", {63'h0, bu_init_o}, {63'h0, !bad});
        chk("early_done", {63'h0, done_o}, {63'h0, bad});
        chk("early_err",  {63'h0, err_o},  {63'h0, bad});
        chk("busy",       {63'h0, busy_o}, 64'h1);
    endtask

    task automatic finish_job();
        int k;
        k = 0;
        while (!done_o && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen",  {63'h0, done_o}, 64'h1);
        chk("err_flag",   {63'h0, err_o},  {63'h0, exp_err});
        chk("en_count",   64'(en_cnt - e0), exp_err ? 64'h0 : 64'(exp_beats));
        chk("read_count", 64'(gnt_cnt - g0), 64'(exp_reads));
        chk("sb_empty",   64'(exp_req_q.size() + exp_wr_q.size()), 64'h0);
        chk("nelem",      {32'h0, bu_nelem_o}, {32'h0, last_n});
        @(negedge clk);
        chk("busy_after_done", {63'h0, busy_o}, 64'h0);
        repeat (6) tick();
        chk("single_done", 64'(done_cnt - d0), 64'h1);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_busy",  {63'h0, busy_o},     64'h0);
        chk("rst_req",   {63'h0, sram_req_o}, 64'h0);
        chk("rst_done",  {63'h0, done_o},     64'h0);
        chk("rst_nelem", {32'h0, bu_nelem_o}, 64'h0);
        rst = 1'b0;
        tick();

        // Normal job
        start_job(32'h100, 32'd20, 16'd5);
        finish_job();

        // Boundary lengths and rejected jobs
        start_job(32'h1000, 32'd1, 16'd1);
        finish_job();
        start_job(32'h8000, 32'd512, 16'd1);
        finish_job();
        start_job(32'h8000, 32'd513, 16'd1);
        finish_job();
        start_job(32'h8000, 32'd0, 16'd1);
        finish_job();
        start_job(32'h8000, 32'd8, 16'd0);
        finish_job();

        // Credit stall: no returns for ~20 cycles
        ret_en = 1'b0;
        start_job(32'h2000, 32'd8, 16'd10);
        repeat (18) @(negedge clk);
        chk("stall_en4", 64'(en_cnt - e0), 64'd4);
        ret_en = 1'b1;
        finish_job();

        // Backpressured SRAM
        sram_gnt_i = 1'b0;
        start_job(32'h3000, 32'd16, 16'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_req",  {63'h0, sram_req_o},  64'h1);
            chk("bp_addr", {32'h0, sram_addr_o}, 64'h3000);
        end
        sram_gnt_i = 1'b1;
        finish_job();

        // Start during FILL is ignored
        start_job(32'h4000, 32'd24, 16'd3);
        @(negedge clk);
        base_addr_i = 32'h9000;
        num_elem_i  = 32'd5;
        num_beats_i = 16'd7;
        start_i     = 1'b1;
        tick();
        start_i = 1'b0;
        finish_job();

        // Reset in the middle of STREAM
        start_job(32'h5000, 32'd16, 16'd8);
        k = 0;
        while ((en_cnt - e0) < 2 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("reached_stream", {63'h0, (en_cnt - e0) >= 2}, 64'h1);
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("mid_rst_busy",  {63'h0, busy_o},     64'h0);
        chk("mid_rst_en",    {63'h0, bu_en_o},    64'h0);
        chk("mid_rst_req",   {63'h0, sram_req_o}, 64'h0);
        chk("mid_rst_valid", {63'h0, bu_valid_o}, 64'h0);
        chk("mid_rst_init",  {63'h0, bu_init_o},  64'h0);
        chk("mid_rst_done",  {62'h0, done_o, err_o}, 64'h0);
        chk("mid_rst_nelem", {32'h0, bu_nelem_o}, 64'h0);
        rst = 1'b0;
        last_n = '0;
        repeat (3) tick();
        start_job(32'h6000, 32'd8, 16'd1);
        finish_job();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/broadcast_ctrl.md
Name: broadcast_ctrl

Overview:
Sequences one broadcast_unit for one operand-broadcast job. On start it clears the unit's cache, then fetches the operand from SRAM in 8-byte beats and writes each beat into the cache. It then issues the requested number of output beats (`en` pulses), gated by downstream credits. It sits between the layer scheduler (start/done) and the broadcast_unit/SRAM read port.

Parameters:
MAX_VECTOR_SIZE, 8, bytes per beat; must match broadcast_unit
CACHE_DEPTH, 512, broadcast cache entries; operand length limit
MAX_ADDR_WIDTH, 32, SRAM/cache address width
BEAT_CNT_WIDTH, 16, width of output beat counter
CREDITS, 4, downstream buffer slots (credit counter init value)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start_i  in  1  job start pulse; sampled only in IDLE
base_addr_i  in  MAX_ADDR_WIDTH  SRAM byte address of operand; 8-byte aligned
num_elem_i  in  32  operand length N in elements
num_beats_i  in  BEAT_CNT_WIDTH  output beats to broadcast
sram_req_o  out  1  SRAM read request
sram_addr_o  out  MAX_ADDR_WIDTH  SRAM read address
sram_gnt_i  in  1  request accepted this cycle
sram_rvalid_i  in  1  read data valid; in-order return
sram_rdata_i  in  64  read data
bu_init_o  out  1  to broadcast_unit init
bu_valid_o  out  1  to broadcast_unit valid_i
bu_addr_o  out  MAX_ADDR_WIDTH  to broadcast_unit addr_i (cache element index)
bu_data_o  out  64  to broadcast_unit data_i
bu_en_o  out  1  to broadcast_unit en
bu_nelem_o  out  32  to broadcast_unit number_of_elements_i; latched N
bu_valid_i  in  1  broadcast_unit valid_o
credit_ret_i  in  1  downstream freed one slot
busy_o  out  1  job in progress
done_o  out  1  one-cycle pulse at job end
err_o  out  1  one-cycle pulse with done_o on rejected job

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; credit counter = CREDITS.
- States: IDLE, INIT, FILL, STREAM, DRAIN, DONE. busy_o=1 in every state except IDLE.
- IDLE + start_i: latch base, N, beats, then check the job.
  - N==0 or N>CACHE_DEPTH or num_beats_i==0: go to DONE, pulse err_o with done_o. No bu_init_o, no SRAM traffic.
  - Otherwise go to INIT.
- INIT: bu_init_o=1 for exactly one cycle, then FILL. fill_beats=ceil(N/8).
- FILL, request side:
  - sram_req_o held high until fill_beats requests are granted.
  - sram_addr_o = base + 8*req_cnt, with req_cnt incremented on sram_gnt_i.
- FILL, return side:
  - Each sram_rvalid_i drives bu_valid_o=1, bu_data_o=sram_rdata_i and bu_addr_o=8*rsp_cnt in the same cycle (combinational pass-through); rsp_cnt increments.
  - Bytes beyond N in the last beat are written anyway; they are unused because the unit wraps at N.
  - After the last response, go to STREAM on the next cycle.
- STREAM:
  - bu_en_o=1 in any cycle where credits>0 and issued<num_beats.
  - Each en cycle decrements credits and increments issued.
  - credit_ret_i increments credits. When en and a return occur in the same cycle, credits are unchanged.
  - credit_ret_i while credits==CREDITS is ignored and credits saturate.
  - When issued==num_beats, go to DRAIN.
- DRAIN: count bu_valid_i pulses in received. When received==num_beats, go to DONE.
- DONE: done_o=1 for one cycle, then IDLE. busy_o falls in that IDLE cycle.
- bu_nelem_o holds the latched N from INIT until the next accepted start. This keeps the unit's wrap-around stable.
- start_i outside IDLE is ignored.
- rst mid-job: the controller returns to IDLE next cycle. Partial SRAM responses arriving afterwards are dropped. The cache is cleared at the next job's INIT.
- Arithmetic:
  - Counters are unsigned.
  - fill_beats = (N+7)>>3, at most 64 for CACHE_DEPTH=512.
  - Address adds wrap modulo 2^MAX_ADDR_WIDTH.

Optional Feature:
BCAST_CTRL_PERF_EN:
- Defined: adds perf_fill_cyc_o[31:0] (cycles spent in FILL) and perf_stall_cyc_o[31:0] (STREAM cycles with issued<num_beats and credits==0).
- Both counters clear at INIT and hold after DONE.
- Undefined: neither port nor counters exist; behaviour otherwise identical.

Decomposition:
- Shared params package holds:
  - state enum bcast_ctrl_state_t (6 states, 3-bit).
  - BEAT_BYTES=8.
  - INT8_SIZE and MAX_ADDR_WIDTH, already shared.
- One sub-module, credit_counter: saturating up/down counter with init value, zero flag and full flag. It is reusable by other stream producers.

Test Plan:
- Normal job:
  - Stimulus: N=20, beats=5, base=0x100, gnt always 1, rvalid 2 cycles after gnt.
  - Response: 3 SRAM reads at 0x100/0x108/0x110; bu_addr 0/8/16; 5 en pulses; done_o after 5th bu_valid_i; err_o=0.
- Credit stall:
  - Stimulus: CREDITS=4, beats=10, no credit_ret_i until cycle 20.
  - Response: exactly 4 en pulses before cycle 20; remaining 6 follow as credits return; simultaneous en+return leaves credits unchanged.
- Boundary N:
  - Stimulus: N=1, then N=512, then N=513, each with beats=1.
  - Response: N=1 gives 1 read; N=512 gives 64 reads; N=513 gives no reads and done_o+err_o together one cycle after start.
- Backpressured SRAM:
  - Stimulus: N=16 with gnt low for 3 cycles.
  - Response: sram_req_o and sram_addr_o=base held stable until gnt; exactly 2 grants accepted.
- Reset mid-job:
  - Stimulus: rst asserted during STREAM after 2 of 8 beats.
  - Response: next cycle all outputs 0 and busy_o=0. A following start with N=8, beats=1 begins with a bu_init_o pulse and completes normally.
- Ignored start:
  - Stimulus: start_i pulsed during FILL.
  - Response: no change to the latched N/beats; a single done_o.
